// File: rtl/alu_pkg.sv
// alu_pkg: ALU select codes shared with the ALU control decoder, FSM state
// encodings for alu_exec, and the single-cycle ALU function.
package alu_pkg;

   localparam int XLEN = 32;

   // ALU select codes
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_XOR   = 4'b0011;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLTU  = 4'b0111;
   localparam logic [3:0] ALU_MUL   = 4'b1000;
   localparam logic [3:0] ALU_MULHU = 4'b1001;
   localparam logic [3:0] ALU_DIVU  = 4'b1010;
   localparam logic [3:0] ALU_REMU  = 4'b1011;

   // FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   // Single-cycle ops. Any other code (including the iterative ones when
   // they land here) yields 0.
   function automatic logic [XLEN-1:0] alu_short(input logic [3:0] sel,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      case (sel)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
         default:  r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: 1-bit-per-cycle shift-add multiplier and (optionally)
// restoring unsigned divider sharing one hi/lo register pair.
//   clk, rst_n   clock, synchronous active-low reset
//   start        load operands (one-cycle pulse on accept)
//   div_mode     1 = divide, 0 = multiply (sampled on start)
//   op_a, op_b   operands
//   done         high during the final iteration cycle
//   res_lo       product[31:0] / quotient  (value after this iteration)
//   res_hi       product[63:32] / remainder (value after this iteration)
// Macro EXEC_DIV_EN: when undefined the divide datapath is not built.
import alu_pkg::*;

module iter_muldiv (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            div_mode,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            done,
   output logic [XLEN-1:0] res_lo,
   output logic [XLEN-1:0] res_hi
);

   logic [XLEN-1:0] hi, lo, m;
   logic [5:0]      cnt;
   logic            busy;
   logic [XLEN-1:0] hi_n, lo_n;
   logic [XLEN:0]   mul_sum;

   // Multiply: hi:lo starts as {0, b}; add a into hi when lo[0] is set,
   // then shift the 65-bit {carry, hi, lo} right by one.
   assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);

`ifdef EXEC_DIV_EN
   logic            dmode;
   logic [XLEN:0]   shl, diff;
   logic            ge;

   // Restoring divide: hi is the partial remainder, lo shifts the dividend
   // out the top and the quotient bits in at the bottom.
   assign shl  = {hi, lo[XLEN-1]};
   assign ge   = shl >= {1'b0, m};
   assign diff = shl - {1'b0, m};

   always_comb begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
      if (dmode) begin
         hi_n = ge ? diff[XLEN-1:0] : shl[XLEN-1:0];
         lo_n = {lo[XLEN-2:0], ge};
      end
   end
`else
   logic unused_div;
   assign unused_div = div_mode;

   always_comb begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi   <= '0;
         lo   <= '0;
         m    <= '0;
         cnt  <= '0;
         busy <= 1'b0;
`ifdef EXEC_DIV_EN
         dmode <= 1'b0;
`endif
      end else if (start) begin
         hi   <= '0;
         cnt  <= '0;
         busy <= 1'b1;
`ifdef EXEC_DIV_EN
         dmode <= div_mode;
         lo    <= div_mode ? op_a : op_b;
         m     <= div_mode ? op_b : op_a;
`else
         lo    <= op_b;
         m     <= op_a;
`endif
      end else if (busy) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= cnt + 6'd1;
         if (cnt == 6'd31) busy <= 1'b0;
      end
   end

   // done coincides with the 32nd iteration so the top can register the
   // final value on that same edge.
   assign done   = busy && (cnt == 6'd31);
   assign res_lo = lo_n;
   assign res_hi = hi_n;

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage unit. Single-cycle logic/arith ops, 32-cycle
// iterative MUL/MULHU and (with EXEC_DIV_EN) DIVU/REMU, with valid/ready
// handshakes on both sides and a registered result.
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_ready   request handshake (in_ready high only in IDLE)
//   alu_sel, op_a, op_b  operation code and unsigned operands
//   out_valid, out_ready result handshake
//   result, zero         registered result and result==0 flag
// Macro EXEC_DIV_EN: enables the iterative divider; when undefined DIVU and
// REMU behave as unknown codes (result 0, latency 1).
import alu_pkg::*;

module alu_exec (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_sel,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   logic [1:0]      state;
   logic            sel_hi;   // MULHU/REMU take the hi half
   logic            accept, is_mul, md_start, md_done;
   logic [XLEN-1:0] short_res, md_lo, md_hi, md_res;

   assign in_ready  = (state == ST_IDLE);
   assign accept    = in_ready && in_valid;
   assign is_mul    = (alu_sel[3:1] == 3'b100);
   assign short_res = alu_short(alu_sel, op_a, op_b);
   assign md_res    = sel_hi ? md_hi : md_lo;

`ifdef EXEC_DIV_EN
   logic is_div, div_zero;
   assign is_div   = (alu_sel[3:1] == 3'b101);
   assign div_zero = (op_b == '0);
   assign md_start = accept && (is_mul || (is_div && !div_zero));
`else
   assign md_start = accept && is_mul;
`endif

   iter_muldiv u_md (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (md_start),
      .div_mode (alu_sel[1]),
      .op_a     (op_a),
      .op_b     (op_b),
      .done     (md_done),
      .res_lo   (md_lo),
      .res_hi   (md_hi)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         sel_hi    <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               sel_hi <= alu_sel[0];
               if (is_mul) begin
                  state <= ST_MUL;
`ifdef EXEC_DIV_EN
               end else if (is_div && !div_zero) begin
                  state <= ST_DIV;
               end else if (is_div) begin
                  // divide by zero: quotient all ones, remainder = dividend
                  result    <= alu_sel[0] ? op_a : '1;
                  zero      <= alu_sel[0] ? (op_a == '0) : 1'b0;
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
`endif
               end else begin
                  result    <= short_res;
                  zero      <= (short_res == '0);
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
               end
            end
            ST_MUL, ST_DIV: if (md_done) begin
               result    <= md_res;
               zero      <= (md_res == '0);
               out_valid <= 1'b1;
               state     <= ST_HOLD;
            end
            default: if (out_ready) begin   // ST_HOLD
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec.
import alu_pkg::*;

module tb_alu_exec;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_sel;
   logic [31:0]     op_a, op_b;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     result;
   logic            zero;

   int total = 0;
   int bad   = 0;
   int lat;
   int rdy_seen;

   always #5 clk = ~clk;

   alu_exec dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_sel   (alu_sel),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request for one edge, then count edges until out_valid.
   // lat = 1 means out_valid right after the accept edge. Also records
   // whether in_ready was ever seen high while waiting.
   task automatic run(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      alu_sel  = s;
      op_a     = a;
      op_b     = b;
      step();
      in_valid = 1'b0;
      op_a     = 32'hDEAD_BEEF;   // later operand changes must be ignored
      op_b     = 32'h1234_5678;
      lat      = 1;
      rdy_seen = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_seen = 1;
         step();
         lat++;
      end
   endtask

   task automatic finish_op();
      // out_ready is high: leave HOLD, back in IDLE after one edge
      step();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      alu_sel   = 4'b0;
      op_a      = '0;
      op_b      = '0;
      out_ready = 1'b1;
      step();
      step();
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'b0, zero}, 32'd0);
      rst_n = 1'b1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // ADD wrap
      run(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
      chk("add_lat", lat, 1);
      chk("add_res", result, 32'h0);
      chk("add_zero", {31'b0, zero}, 32'd1);
      finish_op();
      chk("add_back_ready", {31'b0, in_ready}, 32'd1);

      // MULHU max x max
      run(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mulhu_lat", lat, 33);
      chk("mulhu_res", result, 32'hFFFF_FFFE);
      chk("mulhu_busy_ready", rdy_seen, 0);
      finish_op();

      // MUL low word
      run(ALU_MUL, 32'd12345, 32'd678);
      chk("mul_lat", lat, 33);
      chk("mul_res", result, 32'h007F_B6F6);
      chk("mul_zero", {31'b0, zero}, 32'd0);
      finish_op();

      // MUL low word of max x max = 1
      run(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mul_max_res", result, 32'h1);
      finish_op();

`ifdef EXEC_DIV_EN
      run(ALU_DIVU, 32'd100, 32'd7);
      chk("divu_lat", lat, 33);
      chk("divu_res", result, 32'd14);
      finish_op();
      run(ALU_REMU, 32'd100, 32'd7);
      chk("remu_lat", lat, 33);
      chk("remu_res", result, 32'd2);
      finish_op();
      run(ALU_DIVU, 32'd5, 32'd0);
      chk("divu0_lat", lat, 1);
      chk("divu0_res", result, 32'hFFFF_FFFF);
      finish_op();
      run(ALU_REMU, 32'd5, 32'd0);
      chk("remu0_lat", lat, 1);
      chk("remu0_res", result, 32'd5);
      finish_op();
`else
      run(ALU_DIVU, 32'd100, 32'd7);
      chk("divu_lat", lat, 1);
      chk("divu_res", result, 32'd0);
      chk("divu_zero", {31'b0, zero}, 32'd1);
      finish_op();
      run(ALU_REMU, 32'd100, 32'd7);
      chk("remu_lat", lat, 1);
      chk("remu_res", result, 32'd0);
      finish_op();
      run(ALU_DIVU, 32'd5, 32'd0);
      chk("divu0_lat", lat, 1);
      chk("divu0_res", result, 32'd0);
      finish_op();
      run(ALU_REMU, 32'd5, 32'd0);
      chk("remu0_res", result, 32'd0);
      finish_op();
`endif

      // logic ops
      run(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
      chk("and_res", result, 32'h0000_F000);
      finish_op();
      run(ALU_OR, 32'h0000_F0F0, 32'h0000_FF00);
      chk("or_res", result, 32'h0000_FFF0);
      finish_op();
      run(ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00);
      chk("xor_res", result, 32'h0000_0FF0);
      finish_op();
      run(ALU_SLTU, 32'd5, 32'd3);
      chk("sltu_false", result, 32'd0);
      chk("sltu_false_zero", {31'b0, zero}, 32'd1);
      finish_op();
      run(ALU_SLTU, 32'd3, 32'hFFFF_FFFF);
      chk("sltu_true", result, 32'd1);
      finish_op();
      run(4'b0100, 32'd9, 32'd9);
      chk("unknown_lat", lat, 1);
      chk("unknown_res", result, 32'd0);
      finish_op();

      // SUB with consumer stall
      out_ready = 1'b0;
      run(ALU_SUB, 32'd3, 32'd5);
      chk("sub_lat", lat, 1);
      chk("sub_res", result, 32'hFFFF_FFFE);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_res", result, 32'hFFFF_FFFE);
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      step();
      chk("release_valid", {31'b0, out_valid}, 32'd0);
      chk("release_in_ready", {31'b0, in_ready}, 32'd1);

      // MUL aborted by reset at iteration 10
      in_valid = 1'b1;
      alu_sel  = ALU_MUL;
      op_a     = 32'd7;
      op_b     = 32'd9;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_valid", {31'b0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
      chk("abort_res", result, 32'd0);
      for (int i = 0; i < 40; i++) step();
      chk("abort_no_stale", {31'b0, out_valid}, 32'd0);
      run(ALU_SLTU, 32'd1, 32'd2);
      chk("post_abort_lat", lat, 1);
      chk("post_abort_sltu", result, 32'd1);
      finish_op();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
